// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if
// Bundles every bus-side signal of the memory controller: the LSU request/response
// channel, the instruction-fetch channel, the byte-wide RAM/IO port and the two
// side-band inputs (IO buffer full, ROB rollback). Clock, reset and global ready
// stay plain ports on the controller.
//
// Modports:
//   slave  - the memory controller's view (serves the LSU/fetcher, drives the RAM)
//   master - the environment's view (LSU, fetcher, RAM/IO model, ROB)
interface mem_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // LSU channel
    logic                  enable_from_lsu;
    logic                  read_write_flag_from_lsu;
    logic [2:0]            length_from_lsu;
    logic [ADDR_WIDTH-1:0] address_from_lsu;
    logic [DATA_WIDTH-1:0] data_from_lsu;
    logic                  end_to_lsu;
    logic [DATA_WIDTH-1:0] data_to_lsu;
    logic                  available_to_lsu;

    // Instruction-fetch channel
    logic                  enable_from_fetcher;
    logic [ADDR_WIDTH-1:0] address_from_fetcher;
    logic                  end_to_fetcher;
    logic [DATA_WIDTH-1:0] inst_to_fetcher;

    // Byte-wide RAM/IO port
    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic                  mem_wr;

    // Side-band
    logic                  io_buffer_full;
    logic                  rollback_flag_from_rob;

    modport slave (
        input  enable_from_lsu, read_write_flag_from_lsu, length_from_lsu,
               address_from_lsu, data_from_lsu,
               enable_from_fetcher, address_from_fetcher,
               mem_din, io_buffer_full, rollback_flag_from_rob,
        output end_to_lsu, data_to_lsu, available_to_lsu,
               end_to_fetcher, inst_to_fetcher,
               mem_dout, mem_a, mem_wr
    );

    modport master (
        output enable_from_lsu, read_write_flag_from_lsu, length_from_lsu,
               address_from_lsu, data_from_lsu,
               enable_from_fetcher, address_from_fetcher,
               mem_din, io_buffer_full, rollback_flag_from_rob,
        input  end_to_lsu, data_to_lsu, available_to_lsu,
               end_to_fetcher, inst_to_fetcher,
               mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl
// Serialises 1/2/4-byte LSU loads/stores and 4-byte instruction fetches onto a
// byte-per-cycle RAM/IO port. The LSU has fixed priority over the fetcher and an
// access, once started, is never preempted. Read data is assembled little-endian,
// zero-extended, and returned with a one-cycle end pulse in the DONE state.
//
// Ports:
//   clk_in  - system clock
//   rst_in  - synchronous active-high reset (abandons any access, no end pulse)
//   rdy_in  - global ready; low freezes every register
//   bus     - mem_ctrl_if.slave: LSU channel, fetch channel, RAM port, side-band
//
// Optional feature (macro MEM_CTRL_IO_STALL_EN): a store into the IO region
// (address bits [17:16] == 2'b11) holds off each byte while io_buffer_full is
// high; mem_wr is forced low for those cycles. Without the macro io_buffer_full
// is ignored.
module mem_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int FETCH_BYTES = 4
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    mem_ctrl_if.slave bus
);
    localparam int LANES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Legal lengths are 1, 2 and 4; everything else behaves as a word access.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        case (len)
            3'd1:    norm_len = 3'd1;
            3'd2:    norm_len = 3'd2;
            default: norm_len = 3'd4;
        endcase
    endfunction

    state_t                state_q, state_d;
    logic                  is_fetch_q, is_fetch_d;   // 1 = current access belongs to the fetcher
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            len_q, len_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;         // store bytes not yet sent, byte 0 in [7:0]
    logic [DATA_WIDTH-1:0] buf_q, buf_d;             // read assembly buffer
    logic [DATA_WIDTH-1:0] data_lsu_q, data_lsu_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic                  mem_wr_q, mem_wr_d;

    logic                  io_stall;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [2:0]            cap_idx;
    logic [LANES-1:0]      lane_hit;

    // Address of the byte after the one currently on the bus; wraps naturally.
    assign next_addr = addr_q + ADDR_WIDTH'({1'b0, cnt_q} + 4'd1);

    // In READ, the byte arriving on mem_din this cycle belongs to the address
    // driven one cycle earlier, i.e. byte index cnt_q - 1.
    assign cap_idx = cnt_q - 3'd1;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_hit[gi] = (cap_idx == 3'(gi));
        end
    endgenerate

`ifdef MEM_CTRL_IO_STALL_EN
    assign io_stall = (state_q == WRITE) && (addr_q[17:16] == 2'b11) && bus.io_buffer_full;
`else
    logic unused_io_buffer_full;
    assign unused_io_buffer_full = bus.io_buffer_full;
    assign io_stall = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        is_fetch_d = is_fetch_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        data_lsu_d = data_lsu_q;
        inst_d     = inst_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = 1'b0;

        case (state_q)
            IDLE: begin
                mem_a_d = '0;
                cnt_d   = 3'd0;
                // A flush in the sampling cycle discards whatever is being requested.
                if (!bus.rollback_flag_from_rob) begin
                    if (bus.enable_from_lsu) begin
                        is_fetch_d = 1'b0;
                        addr_d     = bus.address_from_lsu;
                        len_d      = norm_len(bus.length_from_lsu);
                        buf_d      = '0;
                        mem_a_d    = bus.address_from_lsu;
                        if (bus.read_write_flag_from_lsu) begin
                            state_d = READ;
                        end else begin
                            // First store byte goes out in the very next cycle.
                            state_d    = WRITE;
                            mem_wr_d   = 1'b1;
                            mem_dout_d = bus.data_from_lsu[7:0];
                            wdata_d    = bus.data_from_lsu >> 8;
                        end
                    end else if (bus.enable_from_fetcher) begin
                        is_fetch_d = 1'b1;
                        addr_d     = bus.address_from_fetcher;
                        len_d      = 3'(FETCH_BYTES);
                        buf_d      = '0;
                        mem_a_d    = bus.address_from_fetcher;
                        state_d    = READ;
                    end
                end
            end

            READ: begin
                if (bus.rollback_flag_from_rob) begin
                    state_d = IDLE;
                    mem_a_d = '0;
                end else begin
                    // cnt_q counts READ cycles: addresses go out while cnt_q < len,
                    // bytes come back while cnt_q >= 1, so the last one lands at cnt_q == len.
                    for (int b = 0; b < LANES; b++) begin
                        if ((cnt_q != 3'd0) && lane_hit[b]) begin
                            buf_d[8*b +: 8] = bus.mem_din;
                        end
                    end
                    if ((cnt_q + 3'd1) < len_q) begin
                        mem_a_d = next_addr;
                    end
                    if (cnt_q == len_q) begin
                        state_d = DONE;
                        if (is_fetch_q) begin
                            inst_d = buf_d;
                        end else begin
                            data_lsu_d = buf_d;
                        end
                    end
                    cnt_d = cnt_q + 3'd1;
                end
            end

            WRITE: begin
                // Stores are already committed, so rollback is not looked at here.
                if (io_stall) begin
                    mem_wr_d = mem_wr_q;
                end else if ((cnt_q + 3'd1) < len_q) begin
                    mem_wr_d   = 1'b1;
                    mem_a_d    = next_addr;
                    mem_dout_d = wdata_q[7:0];
                    wdata_d    = wdata_q >> 8;
                    cnt_d      = cnt_q + 3'd1;
                end else begin
                    state_d = DONE;
                end
            end

            DONE: begin
                // The requester sees end_* here and drops its enable, so nothing
                // is sampled until the next IDLE cycle.
                state_d = IDLE;
                mem_a_d = '0;
            end

            default: begin
                state_d = IDLE;
                mem_a_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            is_fetch_q <= 1'b0;
            addr_q     <= '0;
            len_q      <= 3'd0;
            cnt_q      <= 3'd0;
            wdata_q    <= '0;
            buf_q      <= '0;
            data_lsu_q <= '0;
            inst_q     <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            is_fetch_q <= is_fetch_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            data_lsu_q <= data_lsu_d;
            inst_q     <= inst_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    assign bus.end_to_lsu       = (state_q == DONE) && !is_fetch_q;
    assign bus.end_to_fetcher   = (state_q == DONE) && is_fetch_q;
    assign bus.data_to_lsu      = data_lsu_q;
    assign bus.inst_to_fetcher  = inst_q;
    assign bus.available_to_lsu = (state_q == IDLE);
    assign bus.mem_a            = mem_a_q;
    assign bus.mem_dout         = mem_dout_q;
    assign bus.mem_wr           = mem_wr_q & ~io_stall;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl
// Self-checking bench for mem_ctrl: a vector table of LSU accesses plus hand-written
// sequences for cycle-exact timing, arbitration, rollback, ready freeze, reset and
// the IO stall option. Read results and RAM byte writes are scoreboarded through
// queues filled when stimulus is driven.
module tb_mem_ctrl;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;

    always #5 clk_in = ~clk_in;

    mem_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FETCH_BYTES(4)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus.slave)
    );

    typedef struct {
        bit          rd;
        logic [2:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        bit          rd;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    int total = 0;
    int bad   = 0;

    rsp_t lsu_exp[$];
    rsp_t fetch_exp[$];
    wr_t  wr_exp[$];

    logic [7:0] ram [bit [31:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic int nbytes(input logic [2:0] len);
        if (len == 3'd1) return 1;
        if (len == 3'd2) return 2;
        return 4;
    endfunction

    // ---------------- RAM model: byte read valid one cycle after mem_a ----------
    logic        wr_s;
    logic [31:0] a_s;
    logic [7:0]  d_s;

    initial begin
        bus.mem_din = 8'd0;
        wr_s = 1'b0;
        a_s  = 32'd0;
        d_s  = 8'd0;
    end

    initial forever begin
        @(negedge clk_in);
        wr_s = bus.mem_wr;
        a_s  = bus.mem_a;
        d_s  = bus.mem_dout;
    end

    // The RAM is part of the system frozen by rdy_in.
    initial forever begin
        @(posedge clk_in);
        if (rdy_in) begin
            if (wr_s) begin
                if (wr_exp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ram_write: unexpected write addr=%h data=%h", a_s, d_s);
                end else begin
                    wr_t w;
                    w = wr_exp.pop_front();
                    check("ram_write_addr", 64'(a_s), 64'(w.a));
                    check("ram_write_data", 64'(d_s), 64'(w.d));
                end
                ram[a_s] = d_s;
            end
            bus.mem_din <= ram_rd(a_s);
        end
    end

    // ---------------- Response monitor ----------------
    initial forever begin
        @(negedge clk_in);
        if (bus.end_to_lsu === 1'b1) begin
            if (lsu_exp.size() == 0) begin
                total++;
                bad++;
                $display("FAIL lsu_end: unexpected end_to_lsu, data=%h", bus.data_to_lsu);
            end else begin
                rsp_t r;
                r = lsu_exp.pop_front();
                if (r.rd) check("lsu_data", 64'(bus.data_to_lsu), 64'(r.data));
            end
        end
        if (bus.end_to_fetcher === 1'b1) begin
            if (fetch_exp.size() == 0) begin
                total++;
                bad++;
                $display("FAIL fetch_end: unexpected end_to_fetcher, inst=%h", bus.inst_to_fetcher);
            end else begin
                rsp_t r;
                r = fetch_exp.pop_front();
                check("fetch_inst", 64'(bus.inst_to_fetcher), 64'(r.data));
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic lsu_drive(input bit rd, input logic [2:0] len, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp, input bit expect_end);
        rsp_t r;
        bus.enable_from_lsu          = 1'b1;
        bus.read_write_flag_from_lsu = rd;
        bus.length_from_lsu          = len;
        bus.address_from_lsu         = addr;
        bus.data_from_lsu            = wdata;
        r.rd   = rd;
        r.data = exp;
        if (expect_end) lsu_exp.push_back(r);
        $display("txn lsu %s len=%0d addr=%h wdata=%h exp=%h", rd ? "rd" : "wr", len, addr, wdata, exp);
    endtask

    task automatic push_writes(input logic [31:0] addr, input logic [31:0] wdata, input int n);
        for (int k = 0; k < n; k++) begin
            wr_t w;
            w.a = addr + 32'(k);
            w.d = wdata[8*k +: 8];
            wr_exp.push_back(w);
        end
    endtask

    task automatic wait_lsu_end(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (bus.end_to_lsu === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 64'(seen), 64'd1);
        bus.enable_from_lsu = 1'b0;
    endtask

    task automatic lsu_txn(input vec_t v);
        @(negedge clk_in);
        if (!v.rd) push_writes(v.addr, v.wdata, nbytes(v.len));
        lsu_drive(v.rd, v.len, v.addr, v.wdata, v.exp, 1'b1);
        wait_lsu_end("lsu_timeout");
    endtask

    vec_t vecs[12];

    initial begin
        int lsu_c;
        int f_c;

        vecs[0]  = '{rd: 1'b1, len: 3'd4, addr: 32'h0000_0100, wdata: 32'h0,          exp: 32'h1234_5678};
        vecs[1]  = '{rd: 1'b0, len: 3'd2, addr: 32'h0000_0300, wdata: 32'h1234_BEEF, exp: 32'h0};
        vecs[2]  = '{rd: 1'b1, len: 3'd4, addr: 32'h0000_0300, wdata: 32'h0,          exp: 32'hA6A7_BEEF};
        vecs[3]  = '{rd: 1'b1, len: 3'd2, addr: 32'h0000_0010, wdata: 32'h0,          exp: 32'h0000_ABCD};
        vecs[4]  = '{rd: 1'b1, len: 3'd3, addr: 32'h0000_0100, wdata: 32'h0,          exp: 32'h1234_5678};
        vecs[5]  = '{rd: 1'b0, len: 3'd4, addr: 32'hFFFF_FFFE, wdata: 32'hDDCC_BBAA, exp: 32'h0};
        vecs[6]  = '{rd: 1'b1, len: 3'd4, addr: 32'hFFFF_FFFE, wdata: 32'h0,          exp: 32'hDDCC_BBAA};
        vecs[7]  = '{rd: 1'b0, len: 3'd0, addr: 32'h0000_0400, wdata: 32'h4433_2211, exp: 32'h0};
        vecs[8]  = '{rd: 1'b1, len: 3'd4, addr: 32'h0000_0400, wdata: 32'h0,          exp: 32'h4433_2211};
        vecs[9]  = '{rd: 1'b1, len: 3'd1, addr: 32'h0000_0101, wdata: 32'h0,          exp: 32'h0000_0056};
        vecs[10] = '{rd: 1'b1, len: 3'd7, addr: 32'h0000_0103, wdata: 32'h0,          exp: 32'hA3A0_A112};
        vecs[11] = '{rd: 1'b1, len: 3'd1, addr: 32'h0000_002F, wdata: 32'h0,          exp: 32'h0000_008A};

        ram[32'h100] = 8'h78;
        ram[32'h101] = 8'h56;
        ram[32'h102] = 8'h34;
        ram[32'h103] = 8'h12;
        ram[32'h010] = 8'hCD;
        ram[32'h011] = 8'hAB;

        bus.enable_from_lsu          = 1'b0;
        bus.read_write_flag_from_lsu = 1'b0;
        bus.length_from_lsu          = 3'd0;
        bus.address_from_lsu         = 32'd0;
        bus.data_from_lsu            = 32'd0;
        bus.enable_from_fetcher      = 1'b0;
        bus.address_from_fetcher     = 32'd0;
        bus.io_buffer_full           = 1'b0;
        bus.rollback_flag_from_rob   = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk_in);
        check("rst_end_lsu",   64'(bus.end_to_lsu), 64'd0);
        check("rst_end_fetch", 64'(bus.end_to_fetcher), 64'd0);
        check("rst_mem_wr",    64'(bus.mem_wr), 64'd0);
        check("rst_mem_a",     64'(bus.mem_a), 64'd0);
        check("rst_available", 64'(bus.available_to_lsu), 64'd1);
        rst_in = 1'b0;

        // ---- table-driven LSU accesses ----
        for (int i = 0; i < 12; i++) lsu_txn(vecs[i]);

        // ---- LW timing: mem_a in C1..C4, end only in C6 ----
        @(negedge clk_in);
        lsu_drive(1'b1, 3'd4, 32'h100, 32'h0, 32'h1234_5678, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk_in);
            if (c <= 4) check("lw_mem_a", 64'(bus.mem_a), 64'(32'h100 + 32'(c - 1)));
            check("lw_end_timing", 64'(bus.end_to_lsu), 64'(c == 6));
            if (c == 6) bus.enable_from_lsu = 1'b0;
        end

        // ---- SB timing ----
        @(negedge clk_in);
        push_writes(32'h204, 32'hFFFF_FFAB, 1);
        lsu_drive(1'b0, 3'd1, 32'h204, 32'hFFFF_FFAB, 32'h0, 1'b1);
        @(negedge clk_in);
        check("sb_c1_wr",   64'(bus.mem_wr), 64'd1);
        check("sb_c1_a",    64'(bus.mem_a), 64'h204);
        check("sb_c1_dout", 64'(bus.mem_dout), 64'hAB);
        @(negedge clk_in);
        check("sb_c2_end", 64'(bus.end_to_lsu), 64'd1);
        check("sb_c2_wr",  64'(bus.mem_wr), 64'd0);
        bus.enable_from_lsu = 1'b0;
        @(negedge clk_in);
        check("sb_c3_wr", 64'(bus.mem_wr), 64'd0);
        check("sb_c3_a",  64'(bus.mem_a), 64'd0);

        // ---- simultaneous LH + fetch: LSU first ----
        @(negedge clk_in);
        lsu_drive(1'b1, 3'd2, 32'h10, 32'h0, 32'h0000_ABCD, 1'b1);
        bus.enable_from_fetcher  = 1'b1;
        bus.address_from_fetcher = 32'h100;
        fetch_exp.push_back('{rd: 1'b1, data: 32'h1234_5678});
        $display("txn fetch addr=%h exp=%h", 32'h100, 32'h1234_5678);
        lsu_c = 0;
        f_c   = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk_in);
            if (c == 6) check("fetch_first_a", 64'(bus.mem_a), 64'h100);
            if (bus.end_to_lsu === 1'b1) begin
                lsu_c = c;
                bus.enable_from_lsu = 1'b0;
            end
            if (bus.end_to_fetcher === 1'b1) begin
                f_c = c;
                bus.enable_from_fetcher = 1'b0;
                break;
            end
        end
        bus.enable_from_fetcher = 1'b0;
        check("arb_lsu_end_cycle",   64'(lsu_c), 64'd4);
        check("arb_fetch_end_cycle", 64'(f_c), 64'd11);

        // ---- rollback in C3 of a fetch ----
        @(negedge clk_in);
        bus.enable_from_fetcher  = 1'b1;
        bus.address_from_fetcher = 32'h100;
        $display("txn fetch addr=%h rollback in C3", 32'h100);
        repeat (3) @(negedge clk_in);
        bus.rollback_flag_from_rob = 1'b1;
        bus.enable_from_fetcher    = 1'b0;
        @(negedge clk_in);
        check("rb_idle",    64'(bus.available_to_lsu), 64'd1);
        check("rb_mem_a",   64'(bus.mem_a), 64'd0);
        check("rb_mem_wr",  64'(bus.mem_wr), 64'd0);
        bus.rollback_flag_from_rob = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_in);
            check("rb_no_end", 64'(bus.end_to_fetcher), 64'd0);
        end

        // ---- rollback in IDLE ignores that cycle's request ----
        @(negedge clk_in);
        bus.rollback_flag_from_rob = 1'b1;
        lsu_drive(1'b1, 3'd1, 32'h101, 32'h0, 32'h0000_0056, 1'b1);
        @(negedge clk_in);
        check("rb_idle_ignored", 64'(bus.available_to_lsu), 64'd1);
        bus.rollback_flag_from_rob = 1'b0;
        wait_lsu_end("rb_idle_timeout");

        // ---- rollback during SW is ignored ----
        @(negedge clk_in);
        push_writes(32'h500, 32'h8765_4321, 4);
        lsu_drive(1'b0, 3'd4, 32'h500, 32'h8765_4321, 32'h0, 1'b1);
        lsu_c = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_in);
            if (c == 2) bus.rollback_flag_from_rob = 1'b1;
            if (c == 4) bus.rollback_flag_from_rob = 1'b0;
            if (bus.end_to_lsu === 1'b1) begin
                lsu_c = c;
                break;
            end
        end
        bus.enable_from_lsu        = 1'b0;
        bus.rollback_flag_from_rob = 1'b0;
        check("sw_rb_end_cycle", 64'(lsu_c), 64'd5);
        check("sw_rb_all_bytes", 64'(wr_exp.size()), 64'd0);
        lsu_txn('{rd: 1'b1, len: 3'd4, addr: 32'h500, wdata: 32'h0, exp: 32'h8765_4321});

        // ---- rdy_in low for 2 cycles mid-LW ----
        @(negedge clk_in);
        lsu_drive(1'b1, 3'd4, 32'h100, 32'h0, 32'h1234_5678, 1'b1);
        lsu_c = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_in);
            if (c >= 2 && c <= 4) check("rdy_frozen_a", 64'(bus.mem_a), 64'h101);
            if (c == 5) check("rdy_resumed_a", 64'(bus.mem_a), 64'h102);
            if (c == 2) rdy_in = 1'b0;
            if (c == 4) rdy_in = 1'b1;
            if (bus.end_to_lsu === 1'b1) begin
                lsu_c = c;
                break;
            end
        end
        rdy_in = 1'b1;
        bus.enable_from_lsu = 1'b0;
        check("rdy_end_cycle", 64'(lsu_c), 64'd8);

        // ---- reset mid-SW: two bytes go out, then everything clears ----
        @(negedge clk_in);
        push_writes(32'h600, 32'h0A0B_0C0D, 2);
        lsu_drive(1'b0, 3'd4, 32'h600, 32'h0A0B_0C0D, 32'h0, 1'b0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        check("mid_rst_mem_wr", 64'(bus.mem_wr), 64'd0);
        check("mid_rst_mem_a",  64'(bus.mem_a), 64'd0);
        check("mid_rst_dout",   64'(bus.mem_dout), 64'd0);
        check("mid_rst_data",   64'(bus.data_to_lsu), 64'd0);
        check("mid_rst_inst",   64'(bus.inst_to_fetcher), 64'd0);
        check("mid_rst_avail",  64'(bus.available_to_lsu), 64'd1);
        rst_in = 1'b0;
        bus.enable_from_lsu = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_in);
            check("mid_rst_no_end", 64'(bus.end_to_lsu), 64'd0);
        end

        // ---- IO region store with io_buffer_full ----
        @(negedge clk_in);
        push_writes(32'h30000, 32'h0000_00AB, 1);
        lsu_drive(1'b0, 3'd1, 32'h30000, 32'h0000_00AB, 32'h0, 1'b1);
        bus.io_buffer_full = 1'b1;
`ifdef MEM_CTRL_IO_STALL_EN
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_in);
            check("io_stall_wr", 64'(bus.mem_wr), 64'd0);
            check("io_stall_end", 64'(bus.end_to_lsu), 64'd0);
        end
        @(posedge clk_in);
        #1 bus.io_buffer_full = 1'b0;
        @(negedge clk_in);
        check("io_go_wr",   64'(bus.mem_wr), 64'd1);
        check("io_go_a",    64'(bus.mem_a), 64'h30000);
        check("io_go_dout", 64'(bus.mem_dout), 64'hAB);
        @(negedge clk_in);
        check("io_end", 64'(bus.end_to_lsu), 64'd1);
        bus.enable_from_lsu = 1'b0;
`else
        @(negedge clk_in);
        check("io_ignored_wr", 64'(bus.mem_wr), 64'd1);
        @(negedge clk_in);
        check("io_ignored_end", 64'(bus.end_to_lsu), 64'd1);
        bus.enable_from_lsu = 1'b0;
        bus.io_buffer_full  = 1'b0;
`endif

        repeat (4) @(negedge clk_in);
        check("lsu_queue_drained",   64'(lsu_exp.size()), 64'd0);
        check("fetch_queue_drained", 64'(fetch_exp.size()), 64'd0);
        check("write_queue_drained", 64'(wr_exp.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
